// File: rtl/gate_sweep.sv
// Stimulus sequencer and checker for the two-input basic-gate block: walks a1/a2 through 00..11,
// compares the gate outputs per vector and reports a pass/fail summary. Optional GATE_SWEEP_LOOP_EN.
module gate_sweep #(
    parameter int DWELL = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] y_in,
    output logic       a1,
    output logic       a2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_mask,
    output logic [2:0] err_cnt
);

    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [1:0]    v_q, v_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          start_prev_q, start_prev_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [6:0]    err_mask_q, err_mask_d;
    logic [2:0]    err_cnt_q, err_cnt_d;
    logic          clr_q, clr_d;

    logic          trig;
    logic          va1, va2;
    logic [6:0]    y_exp;
    logic [6:0]    mism;
    logic [6:0]    base_mask;
    logic [2:0]    base_cnt;
    logic [2:0]    cnt_next;

    always_comb begin
        va1   = v_q[1];
        va2   = v_q[0];
        y_exp = {~(va1 ^ va2), va1 ^ va2, ~(va1 | va2), va1 | va2,
                 ~(va1 & va2), va1 & va2, ~va1};
        mism  = y_in ^ y_exp;
    end

    always_comb begin
        state_d      = state_q;
        v_d          = v_q;
        cnt_d        = cnt_q;
        start_prev_d = start;
        done_d       = 1'b0;
        pass_d       = pass_q;
        err_mask_d   = err_mask_q;
        err_cnt_d    = err_cnt_q;
        clr_d        = 1'b0;
        base_mask    = err_mask_q;
        base_cnt     = err_cnt_q;
        cnt_next     = err_cnt_q;
`ifdef GATE_SWEEP_LOOP_EN
        trig = start;
`else
        trig = start & ~start_prev_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d    = ST_RUN;
                    v_d        = 2'd0;
                    cnt_d      = '0;
                    err_mask_d = 7'd0;
                    err_cnt_d  = 3'd0;
                    pass_d     = 1'b0;
                end
            end
            default: begin
                // After a looped restart the previous results stay visible for the done cycle only
                if (clr_q) begin
                    base_mask = 7'd0;
                    base_cnt  = 3'd0;
                    pass_d    = 1'b0;
                end
                err_mask_d = base_mask;
                err_cnt_d  = base_cnt;
                if (cnt_q == LAST) begin
                    cnt_next   = base_cnt + {2'd0, |mism};
                    cnt_d      = '0;
                    v_d        = v_q + 2'd1;
                    err_mask_d = base_mask | mism;
                    err_cnt_d  = cnt_next;
                    if (v_q == 2'd3) begin
                        done_d = 1'b1;
                        pass_d = (cnt_next == 3'd0);
`ifdef GATE_SWEEP_LOOP_EN
                        if (start) begin
                            clr_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            v_q          <= 2'd0;
            cnt_q        <= '0;
            start_prev_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_mask_q   <= 7'd0;
            err_cnt_q    <= 3'd0;
            clr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_q          <= v_d;
            cnt_q        <= cnt_d;
            start_prev_q <= start_prev_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_mask_q   <= err_mask_d;
            err_cnt_q    <= err_cnt_d;
            clr_q        <= clr_d;
        end
    end

    assign a1       = v_q[1];
    assign a2       = v_q[0];
    assign busy     = (state_q == ST_RUN);
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_mask = err_mask_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_gate_sweep.sv
// Bench for gate_sweep (DWELL = 2): a faultable gate model closes the loop around the DUT.
module tb_gate_sweep;

    localparam int DW = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] y_in;
    logic       a1, a2, busy, done, pass;
    logic [6:0] err_mask;
    logic [2:0] err_cnt;

    logic [6:0] stuck0 = 7'd0;
    logic [6:0] inv = 7'd0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    gate_sweep #(.DWELL(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
        .a1(a1), .a2(a2), .busy(busy), .done(done), .pass(pass),
        .err_mask(err_mask), .err_cnt(err_cnt)
    );

    function automatic logic [6:0] good_gates(input int x1, input int x2);
        logic [6:0] r;
        r[0] = (x1 == 0);
        r[1] = (x1 == 1 && x2 == 1);
        r[2] = !(x1 == 1 && x2 == 1);
        r[3] = (x1 == 1 || x2 == 1);
        r[4] = !(x1 == 1 || x2 == 1);
        r[5] = (x1 != x2);
        r[6] = (x1 == x2);
        return r;
    endfunction

    // Gate block under test, with injectable stuck-at-0 and inversion faults
    assign y_in = (good_gates(int'(a1), int'(a2)) & ~stuck0) ^ inv;

    typedef struct {
        logic [6:0] s0;
        logic [6:0] iv;
        logic [6:0] emask;
        int         ecnt;
        logic       epass;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count vectors where the faulty block disagrees with ideal gates
    task automatic model(input logic [6:0] s0, input logic [6:0] iv,
                         output logic [6:0] m, output int c);
        m = 7'd0;
        c = 0;
        for (int v = 0; v < 4; v++) begin
            logic [6:0] g, d;
            g = good_gates(v / 2, v % 2);
            d = g ^ ((g & ~s0) ^ iv);
            m |= d;
            if (d != 7'd0) c++;
        end
    endtask

    task automatic sweep(input string tag, input logic [6:0] em, input int ec, input logic ep);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, " busy@E0"}, busy, 1);
        chk({tag, " a@E0"}, {a1, a2}, 0);
        for (int j = 1; j < 4 * DW; j++) begin
            tick();
            chk({tag, " a_seq"}, {a1, a2}, j / DW);
            chk({tag, " busy_run"}, busy, 1);
            chk({tag, " done_early"}, done, 0);
        end
        tick();
        chk({tag, " done"}, done, 1);
        chk({tag, " busy_end"}, busy, 0);
        chk({tag, " a_end"}, {a1, a2}, 0);
        chk({tag, " mask"}, err_mask, em);
        chk({tag, " cnt"}, err_cnt, ec);
        chk({tag, " pass"}, pass, ep);
        tick();
        chk({tag, " done_pulse"}, done, 0);
        chk({tag, " mask_hold"}, err_mask, em);
        chk({tag, " cnt_hold"}, err_cnt, ec);
    endtask

    initial begin
        vec_t tbl[5];
        logic [6:0] m;
        int c;
        int ndone;

        tbl[0] = '{7'h00, 7'h00, 7'h00, 0, 1'b1};
        tbl[1] = '{7'h20, 7'h00, 7'h20, 2, 1'b0};
        tbl[2] = '{7'h00, 7'h01, 7'h01, 4, 1'b0};
        tbl[3] = '{7'h02, 7'h00, 7'h02, 1, 1'b0};
        tbl[4] = '{7'h00, 7'h7F, 7'h7F, 4, 1'b0};

        tick();
        tick();
        chk("rst_outs", {a1, a2, busy, done, pass, err_mask, err_cnt}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            stuck0 = tbl[i].s0;
            inv    = tbl[i].iv;
            sweep($sformatf("tbl%0d", i), tbl[i].emask, tbl[i].ecnt, tbl[i].epass);
        end

        for (int i = 0; i < 6; i++) begin
            stuck0 = 7'($urandom) & 7'($urandom);
            inv    = 7'($urandom) & 7'($urandom) & 7'($urandom);
            model(stuck0, inv, m, c);
            sweep($sformatf("rnd%0d", i), m, c, c == 0);
        end
        stuck0 = 7'd0;
        inv    = 7'd0;

        // Mid-sweep start ignored; restart in the done cycle accepted
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int j = 1; j <= 4 * DW; j++) begin
            start = (j == 2);
            tick();
            if (done) ndone++;
        end
        start = 1'b0;
        chk("mid_done_cnt", ndone, 1);
        chk("mid_done_at_end", done, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_busy", busy, 1);
        ndone = 0;
        for (int j = 1; j <= 4 * DW; j++) begin
            tick();
            if (done) ndone++;
        end
        chk("restart_done", done, 1);
        chk("restart_done_cnt", ndone, 1);
        tick();

        // Reset mid-sweep aborts without done
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 4; j++) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_outs", {a1, a2, busy, done, pass, err_mask, err_cnt}, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (done || busy) ndone++;
        end
        chk("abort_no_done", ndone, 0);

        // Start held high for 20 cycles
        start = 1'b1;
        tick();
        ndone = 0;
        c = 0;
        for (int j = 1; j <= 26; j++) begin
            if (j == 20) start = 1'b0;
            tick();
            if (done) ndone++;
`ifdef GATE_SWEEP_LOOP_EN
            if (j < 24 && !busy) c++;
`endif
        end
`ifdef GATE_SWEEP_LOOP_EN
        chk("held_done_cnt", ndone, 3);
        chk("held_busy_gaps", c, 0);
`else
        chk("held_done_cnt", ndone, 1);
        chk("held_idle", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
